asyn_single_8x16ram: RTL and testbench
======================================

ASYN_SINGLE_8X16RAM -- requirements
Module: asyn_single_8x16ram

Interface
REQ-001 Parameter DATA_W, default 16, word width in bits.
REQ-002 Parameter ADDR_W, default 3, address width in bits.
REQ-003 Parameter DEPTH, default 8, number of words; SHALL equal 2**ADDR_W.
REQ-004 clk  input  1  single clock; all writes sample on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 data  inout  DATA_W  bidirectional data bus: write data in, read data out.
REQ-007 addr_in  input  ADDR_W  word address for both read and write.
REQ-008 we_in  input  1  write enable, active high.
REQ-009 en_in  input  1  read (output) enable, active high.

Function
REQ-010 Write mode (we_in=1, en_in=0): at rising clk, mem[addr_in] SHALL take the value on data; data SHALL NOT be driven by the block.
REQ-011 Read mode (we_in=0, en_in=1): data SHALL be driven combinationally with mem[addr_in]; no clock latency; an address change SHALL update data in the same delta, with no edge needed.
REQ-012 Idle (we_in=0, en_in=0): data SHALL be high-Z; memory unchanged.
REQ-013 Conflict (we_in=1, en_in=1): no write occurs; data high-Z; memory unchanged.
REQ-014 data SHALL be driven only when en_in=1 and we_in=0; every other combination leaves data high-Z, giving no bus contention with an external writer.
REQ-015 All addresses 0..DEPTH-1 are valid; no wrap or out-of-range case exists.
REQ-016 Read of a location written at the current clk edge SHALL return the new word after that edge, since the read is combinational from the array.
REQ-017 Unknown or X bits on data during a write SHALL be stored as received; no filtering.

Reset
REQ-018 rst_n=0 SHALL immediately, without waiting for clk, clear all DEPTH words to 0.
REQ-019 While rst_n=0, writes SHALL be ignored; a read-mode output SHALL show 0.
REQ-020 A write edge coincident with reset assertion SHALL be lost; after release the first write edge with rst_n=1 SHALL take effect.
REQ-021 Reset SHALL NOT affect the tri-state rule of REQ-014.

Structure
REQ-022 DATA_W, ADDR_W and DEPTH defaults and a mode encoding (IDLE, WRITE, READ, CONFLICT) SHALL live in a shared package, asyn_ram_pkg.
REQ-023 The block SHALL be flat: a register array, a write process with async clear, and a combinational tri-state read path; no sub-module.

Verification
REQ-024 Reset, then write mode with addr=l and data=l for l=0..7, one clk edge each; then read mode with addr 0..7 -> data reads 0,1,...,7 respectively.
REQ-025 After REQ-024, pulse rst_n low mid-cycle, then read all addresses -> every word 0x0000, cleared before the next clk edge.
REQ-026 Write 0xA5A5 to addr 3 with en_in=1 and we_in=1 -> bus high-Z throughout; a later read of addr 3 returns its prior value (0x0000 after reset).
REQ-027 Idle mode and write mode at any address -> DUT output on data is Z; bench-driven 0xFFFF is seen on the bus without contention.
REQ-028 Write 0x1234 to addr 7, then in read mode step addr 6->7->6 with no clk edge -> data follows immediately: mem[6], 0x1234, mem[6].

Source files
------------

// File: rtl/asyn_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : asyn_ram_pkg
// Description : Shared definitions for the single-port tri-state RAM.
//               Holds the default geometry (DATA_W / ADDR_W / DEPTH) and the
//               bus-mode encoding derived from the {en_in, we_in} pair.
// Revision    : 1.0 - initial release
// ============================================================================
package asyn_ram_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 3;
    localparam int DEPTH_DEF  = 8;

    // Bit 1 is the read enable and bit 0 is the write enable.
    // This lets the mode be formed by concatenating the two strobes.
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WRITE    = 2'b01,
        READ     = 2'b10,
        CONFLICT = 2'b11
    } ram_mode_t;

    // Combines the two strobes into one mode value.
    // Both strobes high is an explicit mode of its own. It is not treated as a write.
    function automatic ram_mode_t decode_mode(input logic we, input logic en);
        return ram_mode_t'({en, we});
    endfunction

endpackage : asyn_ram_pkg
`default_nettype wire

// File: rtl/asyn_single_8x16ram.sv
`default_nettype none
// ============================================================================
// Module      : asyn_single_8x16ram
// Description : Single-port RAM with one bidirectional data bus.
//               Writes happen on the rising clock edge. Reads are fully
//               combinational from the storage array. An asynchronous
//               active-low reset clears every word.
// Ports       : clk     - write clock (rising edge)
//               rst_n   - asynchronous active-low clear of the whole array
//               data    - inout bus: write data in, read data out
//               addr_in - word address shared by read and write
//               we_in   - write enable (active high)
//               en_in   - read/output enable (active high)
// Revision    : 1.0 - initial release
// ============================================================================
module asyn_single_8x16ram
    import asyn_ram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    inout  wire  [DATA_W-1:0] data,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              we_in,
    input  logic              en_in
);

    // The address must cover the array exactly.
    // With that guarantee, every address is valid and no range check is needed.
    generate
        if (DEPTH != (2 ** ADDR_W)) begin : g_depth_check
            $error("DEPTH must equal 2**ADDR_W");
        end
    endgenerate

    ram_mode_t         w_mode;
    logic [DATA_W-1:0] w_rd_data;
    logic [DATA_W-1:0] r_mem [DEPTH];

    assign w_mode = decode_mode(we_in, en_in);

    // Write port. Reset clears the whole array at once, without waiting for a clock edge.
    // While rst_n is low, the reset branch has priority, so any write strobe is ignored.
    // The bus value is stored exactly as received.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_mode == WRITE) begin
            r_mem[addr_in] <= data;
        end
    end

    // The read path is a direct array lookup.
    // An address change reaches the bus immediately.
    // A word written on this edge is visible as soon as the edge has passed.
    assign w_rd_data = r_mem[addr_in];

    // Only the pure read mode drives the bus.
    // Every other mode releases the bus, so an external writer never contends with this block.
    assign data = (w_mode == READ) ? w_rd_data : {DATA_W{1'bz}};

endmodule : asyn_single_8x16ram
`default_nettype wire

// File: tb/tb_asyn_single_8x16ram.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_asyn_single_8x16ram
// Description : Self-checking bench for asyn_single_8x16ram. A plain array
//               models the memory contents. The bench drives the shared bus
//               whenever the RAM must not drive it. Any unexpected drive by
//               the RAM then shows up as a corrupted bus value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_asyn_single_8x16ram;

    logic        clk;
    logic        rst_n;
    logic [2:0]  addr_in;
    logic        we_in;
    logic        en_in;
    logic        tb_oe;
    logic [15:0] tb_drv;
    wire  [15:0] data;

    logic [15:0] model [8];
    int          errors;
    int          checks;

    assign data = tb_oe ? tb_drv : 16'hzzzz;

    asyn_single_8x16ram #(
        .DATA_W (16),
        .ADDR_W (3),
        .DEPTH  (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data    (data),
        .addr_in (addr_in),
        .we_in   (we_in),
        .en_in   (en_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    endtask

    // Performs one write cycle and records the write in the model.
    task automatic do_write(input logic [2:0] a, input logic [15:0] v);
        @(negedge clk);
        we_in = 1'b1; en_in = 1'b0; addr_in = a; tb_oe = 1'b1; tb_drv = v;
        @(posedge clk);
        model[a] = v;
        @(negedge clk);
        we_in = 1'b0; tb_oe = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; we_in = 1'b0; en_in = 1'b0; addr_in = 3'd0;
        tb_oe = 1'b0; tb_drv = 16'h0000;
        #1 rst_n = 1'b0;
        model_clear();
        en_in = 1'b1;
        for (int a = 0; a < 8; a++) begin
            addr_in = a[2:0];
            #1;
            checks++;
            if (data !== 16'h0000) begin
                errors++;
                $display("FAIL reset_read addr=%0d got=%h exp=0000", a, data);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        en_in = 1'b0;
    endtask

    task automatic test_write_read_seq();
        for (int a = 0; a < 8; a++) do_write(a[2:0], a[15:0]);
        @(negedge clk);
        en_in = 1'b1; we_in = 1'b0;
        for (int a = 0; a < 8; a++) begin
            addr_in = a[2:0];
            #0.5;
            checks++;
            if (data !== a[15:0]) begin
                errors++;
                $display("FAIL seq_read addr=%0d got=%h exp=%h", a, data, a[15:0]);
            end
        end
    endtask

    task automatic test_reset_clear();
        @(negedge clk);
        en_in = 1'b1; we_in = 1'b0; addr_in = 3'd7;
        #0.5;
        checks++;
        if (data !== model[7]) begin
            errors++;
            $display("FAIL pre_clear_read got=%h exp=%h", data, model[7]);
        end
        // The reset pulse sits in the middle of the low phase.
        // All reads below finish before the next rising edge.
        #0.5 rst_n = 1'b0;
        #0.5 rst_n = 1'b1;
        model_clear();
        for (int a = 0; a < 8; a++) begin
            addr_in = a[2:0];
            #0.3;
            checks++;
            if (data !== model[a]) begin
                errors++;
                $display("FAIL clear_read addr=%0d got=%h exp=%h", a, data, model[a]);
            end
        end
        en_in = 1'b0;
    endtask

    // Runs one conflict cycle on addr 3 while the bench drives A5A5.
    // The bus must show only the bench value, and the stored word must stay unchanged.
    task automatic conflict_at3();
        @(negedge clk);
        we_in = 1'b1; en_in = 1'b1; addr_in = 3'd3; tb_oe = 1'b1; tb_drv = 16'hA5A5;
        #1;
        checks++;
        if (data !== 16'hA5A5) begin
            errors++;
            $display("FAIL conflict_bus got=%h exp=a5a5", data);
        end
        @(posedge clk);
        #1;
        checks++;
        if (data !== 16'hA5A5) begin
            errors++;
            $display("FAIL conflict_bus_post got=%h exp=a5a5", data);
        end
        @(negedge clk);
        we_in = 1'b0; en_in = 1'b1; tb_oe = 1'b0;
        #1;
        checks++;
        if (data !== model[3]) begin
            errors++;
            $display("FAIL conflict_readback got=%h exp=%h", data, model[3]);
        end
        en_in = 1'b0;
    endtask

    task automatic test_conflict();
        conflict_at3();
        do_write(3'd3, 16'h5A5A);
        conflict_at3();
    endtask

    task automatic test_no_contention();
        for (int a = 0; a < 8; a++) do_write(a[2:0], 16'h8000 | 16'($urandom_range(1, 32767)));
        for (int a = 0; a < 8; a++) begin
            @(negedge clk);
            we_in = 1'b0; en_in = 1'b0; addr_in = a[2:0]; tb_oe = 1'b1;
            tb_drv = 16'h0000;
            #1;
            checks++;
            if (data !== 16'h0000) begin
                errors++;
                $display("FAIL idle_bus0 addr=%0d got=%h exp=0000", a, data);
            end
            tb_drv = 16'hFFFF;
            #1;
            checks++;
            if (data !== 16'hFFFF) begin
                errors++;
                $display("FAIL idle_busF addr=%0d got=%h exp=ffff", a, data);
            end
            // In write mode the bench drives a value with bits the stored word lacks.
            // If the RAM also drove the bus, the observed value would be corrupted.
            we_in = 1'b1;
            tb_drv = ~model[a];
            #1;
            checks++;
            if (data !== ~model[a]) begin
                errors++;
                $display("FAIL write_bus addr=%0d got=%h exp=%h", a, data, ~model[a]);
            end
            @(posedge clk);
            model[a] = tb_drv;
        end
        @(negedge clk);
        we_in = 1'b0; en_in = 1'b0; tb_oe = 1'b0;
    endtask

    task automatic test_addr_follow();
        do_write(3'd6, 16'h0F0F);
        do_write(3'd7, 16'h1234);
        @(negedge clk);
        we_in = 1'b0; en_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            addr_in = (k == 1) ? 3'd7 : 3'd6;
            #0.5;
            checks++;
            if (data !== model[addr_in]) begin
                errors++;
                $display("FAIL addr_follow step=%0d got=%h exp=%h", k, data, model[addr_in]);
            end
        end
        en_in = 1'b0;
    endtask

    task automatic test_reset_blocks_write();
        @(negedge clk);
        rst_n = 1'b0;
        model_clear();
        we_in = 1'b1; en_in = 1'b0; addr_in = 3'd2; tb_oe = 1'b1; tb_drv = 16'hBEEF;
        @(posedge clk);
        @(negedge clk);
        we_in = 1'b0; en_in = 1'b1; tb_oe = 1'b0;
        #1;
        checks++;
        if (data !== 16'h0000) begin
            errors++;
            $display("FAIL read_in_reset got=%h exp=0000", data);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (data !== 16'h0000) begin
            errors++;
            $display("FAIL write_ignored_in_reset got=%h exp=0000", data);
        end
        en_in = 1'b0;
        do_write(3'd2, 16'hBEEF);
        en_in = 1'b1; addr_in = 3'd2;
        #1;
        checks++;
        if (data !== 16'hBEEF) begin
            errors++;
            $display("FAIL first_write_after_release got=%h exp=beef", data);
        end
        en_in = 1'b0;
    endtask

    task automatic test_random();
        logic        rd;
        logic [15:0] v;
        logic [15:0] exp;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            we_in   = 1'($urandom_range(0, 1));
            en_in   = 1'($urandom_range(0, 1));
            addr_in = 3'($urandom_range(0, 7));
            v       = 16'($urandom);
            rd      = en_in && !we_in;
            tb_oe   = !rd;
            tb_drv  = v;
            #1;
            exp = rd ? model[addr_in] : v;
            checks++;
            if (data !== exp) begin
                errors++;
                $display("FAIL rand_bus n=%0d we=%b en=%b addr=%0d got=%h exp=%h",
                         n, we_in, en_in, addr_in, data, exp);
            end
            @(posedge clk);
            if (we_in && !en_in) model[addr_in] = v;
            #1;
            if (rd) begin
                checks++;
                if (data !== model[addr_in]) begin
                    errors++;
                    $display("FAIL rand_post n=%0d addr=%0d got=%h exp=%h",
                             n, addr_in, data, model[addr_in]);
                end
            end
        end
        // Read the whole array back, so that writes made during the random phase are confirmed.
        @(negedge clk);
        we_in = 1'b0; en_in = 1'b1; tb_oe = 1'b0;
        for (int a = 0; a < 8; a++) begin
            addr_in = a[2:0];
            #0.5;
            checks++;
            if (data !== model[a]) begin
                errors++;
                $display("FAIL rand_final addr=%0d got=%h exp=%h", a, data, model[a]);
            end
        end
        en_in = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_write_read_seq();
        test_reset_clear();
        test_conflict();
        test_no_contention();
        test_addr_follow();
        test_reset_blocks_write();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_asyn_single_8x16ram
`default_nettype wire
